// File: rtl/fsm_timed_controller_if.sv
// Command/status bundle for fsm_timed_controller.
//
// Handshake: there is no ready signal. The controller accepts a start only in
// IDLE, or on the last COMPLETE cycle when AUTO_RESTART is set. A start
// presented at any other time is dropped, not queued. len is sampled only on
// the edge where a start is accepted. abort is a level that is honoured only
// while the controller is ACTIVE. The command source watches busy/done to
// decide when it may issue a new start.
//
// Signals:
//   start, len, abort        command source -> controller
//   busy, done, aborted      controller status
//   active_cnt               remaining ACTIVE cycles after the current one
//   dbg_state                encoded FSM state (0 IDLE, 1 ACTIVE, 2 COMPLETE)
interface fsm_timed_controller_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             done;
  logic             aborted;
  logic [CNT_W-1:0] active_cnt;
  logic [1:0]       dbg_state;

  modport master (
    output start, len, abort,
    input  busy, done, aborted, active_cnt, dbg_state
  );

  modport slave (
    input  start, len, abort,
    output busy, done, aborted, active_cnt, dbg_state
  );
endinterface

// File: rtl/fsm_timed_controller.sv
// Start/done sequencing controller: IDLE -> ACTIVE -> COMPLETE -> IDLE.
// The ACTIVE length comes from len and is sampled with each accepted start.
// COMPLETE lasts DONE_HOLD cycles. abort cuts ACTIVE short and flags the
// result as aborted. With AUTO_RESTART set, a start on the last COMPLETE
// cycle launches the next op directly, without passing through IDLE.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; discards any operation in progress
//   bus    fsm_timed_controller_if.slave (start/len/abort in, status out)
//
// All outputs are decoded from registered state, so no input has a
// combinational path to an output.
module fsm_timed_controller #(
  parameter int CNT_W        = 8,
  parameter int DONE_HOLD    = 1,
  parameter int AUTO_RESTART = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  fsm_timed_controller_if.slave  bus
);

  localparam int HOLD_W = $clog2(DONE_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(DONE_HOLD - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACTIVE   = 2'd1,
    S_COMPLETE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              aborted_q, aborted_d;
  logic              launch;

  // A new op starts from IDLE, or from the last COMPLETE cycle when
  // auto-restart is enabled.
  always_comb begin
    launch = 1'b0;
    if (bus.start) begin
      if (state_q == S_IDLE) begin
        launch = 1'b1;
      end else if (state_q == S_COMPLETE && hold_q == '0 && AUTO_RESTART != 0) begin
        launch = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    aborted_d = aborted_q;
    if (launch) begin
      aborted_d = 1'b0;
      if (bus.len != '0) begin
        state_d = S_ACTIVE;
        cnt_d   = bus.len - CNT_ONE;
      end else begin
        // A zero-length op still produces a done pulse.
        state_d = S_COMPLETE;
        cnt_d   = '0;
        hold_d  = HOLD_LOAD;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d     = '0;
          aborted_d = 1'b0;
        end
        S_ACTIVE: begin
          // abort takes priority over reaching the terminal count.
          if (bus.abort) begin
            state_d   = S_COMPLETE;
            cnt_d     = '0;
            hold_d    = HOLD_LOAD;
            aborted_d = 1'b1;
          end else if (cnt_q == '0) begin
            state_d   = S_COMPLETE;
            hold_d    = HOLD_LOAD;
            aborted_d = 1'b0;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_COMPLETE: begin
          if (hold_q != '0) begin
            hold_d = hold_q - HOLD_W'(1);
          end else begin
            state_d   = S_IDLE;
            aborted_d = 1'b0;
          end
        end
        default: begin
          // An illegal encoding recovers to IDLE.
          state_d   = S_IDLE;
          cnt_d     = '0;
          hold_d    = '0;
          aborted_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      aborted_q <= aborted_d;
    end
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_COMPLETE);
  assign bus.aborted    = (state_q == S_COMPLETE) && aborted_q;
  assign bus.active_cnt = (state_q == S_ACTIVE) ? cnt_q : '0;
  assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_fsm_timed_controller.sv
// Directed bench for fsm_timed_controller. It instantiates three controllers:
//   dut_a  defaults (DONE_HOLD=1, AUTO_RESTART=0)
//   dut_r  AUTO_RESTART=1
//   dut_h  DONE_HOLD=3
// Status is compared as the 11-bit word {busy, done, aborted, active_cnt}.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// "Cycle k" means k edges after the start was presented.
module tb_fsm_timed_controller;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [10:0] exp_st;

  always #5 clk = ~clk;

  fsm_timed_controller_if #(.CNT_W(8)) ifa ();
  fsm_timed_controller_if #(.CNT_W(8)) ifr ();
  fsm_timed_controller_if #(.CNT_W(8)) ifh ();

  fsm_timed_controller #(.CNT_W(8), .DONE_HOLD(1), .AUTO_RESTART(0)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.slave));
  fsm_timed_controller #(.CNT_W(8), .DONE_HOLD(1), .AUTO_RESTART(1)) dut_r (
    .clk(clk), .reset(reset), .bus(ifr.slave));
  fsm_timed_controller #(.CNT_W(8), .DONE_HOLD(3), .AUTO_RESTART(0)) dut_h (
    .clk(clk), .reset(reset), .bus(ifh.slave));

  wire [10:0] st_a = {ifa.busy, ifa.done, ifa.aborted, ifa.active_cnt};
  wire [10:0] st_r = {ifr.busy, ifr.done, ifr.aborted, ifr.active_cnt};
  wire [10:0] st_h = {ifh.busy, ifh.done, ifh.aborted, ifh.active_cnt};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ifa.start = 0; ifa.len = '0; ifa.abort = 0;
    ifr.start = 0; ifr.len = '0; ifr.abort = 0;
    ifh.start = 0; ifh.len = '0; ifh.abort = 0;
    tick(); tick();
    exp_st = 11'd0;
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL reset_a st=%h exp=%h", st_a, exp_st); end
    n_checks++; if (st_r !== exp_st) begin n_errors++; $display("FAIL reset_r st=%h exp=%h", st_r, exp_st); end
    n_checks++; if (st_h !== exp_st) begin n_errors++; $display("FAIL reset_h st=%h exp=%h", st_h, exp_st); end
    n_checks++; if (ifa.dbg_state !== 2'd0) begin n_errors++; $display("FAIL reset_state st=%0d exp=0", ifa.dbg_state); end
    reset = 1'b0;
    tick();
  endtask

  // len=3: ACTIVE cycles 1-3 with active_cnt 2,1,0, done cycle 4, IDLE cycle 5.
  task automatic test_basic();
    ifa.start = 1; ifa.len = 8'd3;
    tick(); ifa.start = 0;
    exp_st = {3'b100, 8'd2};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL basic_c1 st=%h exp=%h", st_a, exp_st); end
    n_checks++; if (ifa.dbg_state !== 2'd1) begin n_errors++; $display("FAIL basic_state st=%0d exp=1", ifa.dbg_state); end
    tick(); exp_st = {3'b100, 8'd1};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL basic_c2 st=%h exp=%h", st_a, exp_st); end
    tick(); exp_st = {3'b100, 8'd0};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL basic_c3 st=%h exp=%h", st_a, exp_st); end
    tick(); exp_st = {3'b110, 8'd0};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL basic_c4 st=%h exp=%h", st_a, exp_st); end
    tick(); exp_st = 11'd0;
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL basic_c5 st=%h exp=%h", st_a, exp_st); end
  endtask

  // len=0: straight to COMPLETE at cycle 1, IDLE at cycle 2.
  task automatic test_zero_len();
    ifa.start = 1; ifa.len = 8'd0;
    tick(); ifa.start = 0;
    exp_st = {3'b110, 8'd0};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL zero_c1 st=%h exp=%h", st_a, exp_st); end
    tick(); exp_st = 11'd0;
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL zero_c2 st=%h exp=%h", st_a, exp_st); end
  endtask

  // len=10, abort raised in cycle 2, then abort against the terminal count,
  // then abort alone in IDLE, then abort together with start in IDLE.
  task automatic test_abort();
    ifa.start = 1; ifa.len = 8'd10;
    tick(); ifa.start = 0;
    exp_st = {3'b100, 8'd9};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL abort_c1 st=%h exp=%h", st_a, exp_st); end
    tick(); ifa.abort = 1;
    exp_st = {3'b100, 8'd8};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL abort_c2 st=%h exp=%h", st_a, exp_st); end
    tick(); ifa.abort = 0;
    exp_st = {3'b111, 8'd0};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL abort_c3 st=%h exp=%h", st_a, exp_st); end
    tick(); exp_st = 11'd0;
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL abort_c4 st=%h exp=%h", st_a, exp_st); end
    // len=1 with abort on the only ACTIVE cycle: the op is still reported aborted.
    ifa.start = 1; ifa.len = 8'd1;
    tick(); ifa.start = 0; ifa.abort = 1;
    tick(); ifa.abort = 0;
    exp_st = {3'b111, 8'd0};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL abort_term st=%h exp=%h", st_a, exp_st); end
    tick();
    // An abort in IDLE does nothing.
    ifa.abort = 1;
    tick(); ifa.abort = 0;
    exp_st = 11'd0;
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL abort_idle st=%h exp=%h", st_a, exp_st); end
    // start wins over abort in IDLE.
    ifa.start = 1; ifa.abort = 1; ifa.len = 8'd2;
    tick(); ifa.start = 0; ifa.abort = 0;
    exp_st = {3'b100, 8'd1};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL abort_start st=%h exp=%h", st_a, exp_st); end
    tick(); tick();
    exp_st = {3'b110, 8'd0};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL abort_start_done st=%h exp=%h", st_a, exp_st); end
    tick();
  endtask

  // start held high with len=2. Without auto-restart the controller spends one
  // IDLE cycle (4) and is ACTIVE again at 5; with it, ACTIVE follows at 4.
  task automatic test_back_to_back();
    int guard;
    ifa.start = 1; ifa.len = 8'd2;
    ifr.start = 1; ifr.len = 8'd2;
    tick(); tick(); tick();
    exp_st = {3'b110, 8'd0};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL b2b_a_c3 st=%h exp=%h", st_a, exp_st); end
    n_checks++; if (st_r !== exp_st) begin n_errors++; $display("FAIL b2b_r_c3 st=%h exp=%h", st_r, exp_st); end
    tick(); ifr.start = 0;
    exp_st = 11'd0;
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL b2b_a_c4 st=%h exp=%h", st_a, exp_st); end
    exp_st = {3'b100, 8'd1};
    n_checks++; if (st_r !== exp_st) begin n_errors++; $display("FAIL b2b_r_c4 st=%h exp=%h", st_r, exp_st); end
    tick(); ifa.start = 0;
    exp_st = {3'b100, 8'd1};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL b2b_a_c5 st=%h exp=%h", st_a, exp_st); end
    guard = 0;
    while ((ifa.busy || ifr.busy) && guard < 20) begin
      tick(); guard++;
    end
    n_checks++; if (guard >= 20) begin n_errors++; $display("FAIL b2b_drain busy_a=%b busy_r=%b exp=0", ifa.busy, ifr.busy); end
  endtask

  // Reset issued in cycle 4 of a len=8 op: outputs are all zero at cycle 5,
  // and a start presented during reset is not accepted.
  task automatic test_reset_mid_op();
    ifa.start = 1; ifa.len = 8'd8;
    tick(); ifa.start = 0;
    tick(); tick(); tick();
    exp_st = {3'b100, 8'd4};
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL rst_c4 st=%h exp=%h", st_a, exp_st); end
    reset = 1; ifa.start = 1;
    tick();
    exp_st = 11'd0;
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL rst_c5 st=%h exp=%h", st_a, exp_st); end
    tick(); reset = 0; ifa.start = 0;
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL rst_c6 st=%h exp=%h", st_a, exp_st); end
    tick();
    n_checks++; if (st_a !== exp_st) begin n_errors++; $display("FAIL rst_c7 st=%h exp=%h", st_a, exp_st); end
  endtask

  // DONE_HOLD=3, len=1: ACTIVE cycle 1, done cycles 2-4, and a start in
  // cycle 3 is dropped.
  task automatic test_done_hold();
    ifh.start = 1; ifh.len = 8'd1;
    tick(); ifh.start = 0;
    exp_st = {3'b100, 8'd0};
    n_checks++; if (st_h !== exp_st) begin n_errors++; $display("FAIL hold_c1 st=%h exp=%h", st_h, exp_st); end
    tick(); exp_st = {3'b110, 8'd0};
    n_checks++; if (st_h !== exp_st) begin n_errors++; $display("FAIL hold_c2 st=%h exp=%h", st_h, exp_st); end
    tick(); ifh.start = 1;
    n_checks++; if (st_h !== exp_st) begin n_errors++; $display("FAIL hold_c3 st=%h exp=%h", st_h, exp_st); end
    tick(); ifh.start = 0;
    n_checks++; if (st_h !== exp_st) begin n_errors++; $display("FAIL hold_c4 st=%h exp=%h", st_h, exp_st); end
    tick(); exp_st = 11'd0;
    n_checks++; if (st_h !== exp_st) begin n_errors++; $display("FAIL hold_c5 st=%h exp=%h", st_h, exp_st); end
    tick();
    n_checks++; if (st_h !== exp_st) begin n_errors++; $display("FAIL hold_c6 st=%h exp=%h", st_h, exp_st); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_abort();
    test_back_to_back();
    test_reset_mid_op();
    test_done_hold();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
